axi_xbar_1xn: RTL and testbench
===============================

// Module: axi_xbar_1xn
// PURPOSE
//  1-master to NUM_SLAVES AXI4 address decoder/router on the clk_gate SoC bus; parametrised successor to the fixed 1x2 xbar.
//  Tracks outstanding read/write bursts so R/B routing stays correct across multiple bursts.
//  Sequences W behind AW and optionally terminates unmapped addresses with DECERR.
// PARAMETERS
//  NUM_SLAVES      4              number of slave ports (2..8)
//  ADDR_W          32             address width
//  DATA_W          32             data width; strb = DATA_W/8
//  ID_W            4              AXI id width
//  MAX_OUTSTANDING 4              max in-flight bursts per direction (1..15)
//  SLV_BASE        {NUM_SLAVES{ADDR_W}}  flattened region bases; slave i = bits [i*ADDR_W +: ADDR_W]
//  SLV_SIZE        {NUM_SLAVES{ADDR_W}}  flattened region sizes; region i = [base, base+size)
// PORTS
//  clk_gate   in   1                  clock
//  rst_n      in   1                  asynchronous reset, active-low
//  m_ar_valid/m_ar_ready  in/out  1   master AR handshake
//  m_ar_id/addr/len/size/burst/lock/cache/prot  in  ID_W/ADDR_W/8/3/2/2/4/3   AR payload
//  m_r_valid/m_r_ready    out/in  1   master R handshake
//  m_r_id/data/resp/last  out  ID_W/DATA_W/2/1   R payload
//  m_aw_*, m_w_*, m_b_*   same shape as AR/R; W = data/strb/last, B = id/resp
//  s_ar_valid, s_aw_valid, s_w_valid, s_r_ready, s_b_ready  out  NUM_SLAVES   per-slave one-hot controls
//  s_ar_ready, s_aw_ready, s_w_ready, s_r_valid, s_b_valid  in   NUM_SLAVES   per-slave handshakes
//  s_ar_*/s_aw_*/s_w_*   out  shared    master payload broadcast to all slaves
//  s_r_*/s_b_*           in   NUM_SLAVES x field   flattened slave payloads
// BEHAVIOUR
//  Decode
//  - Combinational on addr.
//  - Lowest-index matching region wins.
//  - No match: DECERR target (macro on) or slave 0 (macro off).
//  Read path
//  - Registers: rd_sel and rd_cnt, width clog2(MAX_OUTSTANDING+1).
//  - AR forwarded (s_ar_valid[dec]=m_ar_valid, m_ar_ready=s_ar_ready[dec]) only when
//    (rd_cnt==0 || dec==rd_sel) && rd_cnt<MAX_OUTSTANDING. Otherwise m_ar_ready=0 and all s_ar_valid=0.
//  - AR handshake: rd_sel<=dec, rd_cnt+1.
//  - R handshake with last: rd_cnt-1. Both events in one cycle: rd_cnt unchanged.
//  - R muxed from rd_sel; s_r_ready driven only to rd_sel, all other bits 0.
//  Write path
//  - W FSM: W_IDLE -> W_DATA on AW handshake (latch w_sel=dec); W_DATA -> W_IDLE on W handshake with last.
//  - AW is accepted only in W_IDLE, under the same same-target/MAX rule using wr_sel/b_cnt.
//  - W is routed only in W_DATA, to w_sel. In W_IDLE m_w_ready=0 and all s_w_valid=0 (W before AW stalls).
//  - AW handshake: wr_sel<=dec, b_cnt+1. B handshake: b_cnt-1. Simultaneous events: b_cnt unchanged.
//  - B muxed from wr_sel; s_b_ready driven only to wr_sel.
//  Latency, reset, invariants
//  - Zero-cycle combinational pass-through; no payload registering.
//  - Reset: rd_sel=wr_sel=w_sel=0, rd_cnt=b_cnt=0, W_IDLE, DECERR engines idle.
//    Hence m_w_ready=0, m_r_valid=0 and m_b_valid=0 until a transaction is accepted.
//  - Reset mid-burst abandons all tracking; the bench re-resets the slaves too.
//  - Counters never wrap: at MAX_OUTSTANDING new AR/AW stall; a decrement at 0 is an assertion error.
// CONFIGURATION
//  AXI_XBAR_DECERR_EN defined: internal error target at index NUM_SLAVES.
//  - Read: accepts AR when rd_cnt==0, latches id/len.
//    Drives len+1 R beats starting the cycle after the AR handshake: data 0, resp 2'b11, last on the final beat, id echoed.
//  - Write: after AW, w_ready=1 (sinks the beats). One cycle after W last: B with resp 2'b11 and the AW id.
//  AXI_XBAR_DECERR_EN undefined: unmapped addresses go to slave 0; no error logic is instantiated.
// TESTING
//  1. AR addr=SLV_BASE[2], len=3, slave 2 returns 4 beats -> only s_ar_valid[2] and s_r_ready[2] asserted; rd_cnt 1->0 on last.
//  2. Two ARs to slave 1 back-to-back, then AR to slave 0 -> third stalls (m_ar_ready=0) until both slave-1 lasts, then forwards.
//  3. MAX_OUTSTANDING=2, three ARs to slave 0 with R held -> third stalls; one R last in the same cycle as a new AR keeps rd_cnt=2.
//  4. W valid 3 cycles before AW to slave 3 (len=1) -> m_w_ready=0 until the AW handshake; 2 beats reach slave 3; B routed from slave 3.
//  5. Macro on: AR unmapped addr, len=2, id=5 -> 3 R beats, resp=11, id=5, last on beat 3; AW/W unmapped -> B resp=11.
//  6. Macro off: AR unmapped addr -> routed to slave 0. Assert rst_n mid-burst -> counters 0, W_IDLE, m_w_ready=0.

Source files
------------

// File: rtl/axi_xbar_1xn.sv
// 1-master to NUM_SLAVES AXI4 address router with outstanding-burst tracking for R/B return routing.
// Optional DECERR target for unmapped addresses is enabled with `define AXI_XBAR_DECERR_EN.
module axi_xbar_1xn #(
   parameter int NUM_SLAVES      = 4,
   parameter int ADDR_W          = 32,
   parameter int DATA_W          = 32,
   parameter int ID_W            = 4,
   parameter int MAX_OUTSTANDING = 4,
   parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_BASE =
      {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000},
   parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_SIZE = {4{32'h1000_0000}}
) (
   input  logic                         clk_gate,
   input  logic                         rst_n,
   input  logic                         m_ar_valid,
   output logic                         m_ar_ready,
   input  logic [ID_W-1:0]              m_ar_id,
   input  logic [ADDR_W-1:0]            m_ar_addr,
   input  logic [7:0]                   m_ar_len,
   input  logic [2:0]                   m_ar_size,
   input  logic [1:0]                   m_ar_burst,
   input  logic [1:0]                   m_ar_lock,
   input  logic [3:0]                   m_ar_cache,
   input  logic [2:0]                   m_ar_prot,
   output logic                         m_r_valid,
   input  logic                         m_r_ready,
   output logic [ID_W-1:0]              m_r_id,
   output logic [DATA_W-1:0]            m_r_data,
   output logic [1:0]                   m_r_resp,
   output logic                         m_r_last,
   input  logic                         m_aw_valid,
   output logic                         m_aw_ready,
   input  logic [ID_W-1:0]              m_aw_id,
   input  logic [ADDR_W-1:0]            m_aw_addr,
   input  logic [7:0]                   m_aw_len,
   input  logic [2:0]                   m_aw_size,
   input  logic [1:0]                   m_aw_burst,
   input  logic [1:0]                   m_aw_lock,
   input  logic [3:0]                   m_aw_cache,
   input  logic [2:0]                   m_aw_prot,
   input  logic                         m_w_valid,
   output logic                         m_w_ready,
   input  logic [DATA_W-1:0]            m_w_data,
   input  logic [DATA_W/8-1:0]          m_w_strb,
   input  logic                         m_w_last,
   output logic                         m_b_valid,
   input  logic                         m_b_ready,
   output logic [ID_W-1:0]              m_b_id,
   output logic [1:0]                   m_b_resp,
   output logic [NUM_SLAVES-1:0]        s_ar_valid,
   input  logic [NUM_SLAVES-1:0]        s_ar_ready,
   output logic [ID_W-1:0]              s_ar_id,
   output logic [ADDR_W-1:0]            s_ar_addr,
   output logic [7:0]                   s_ar_len,
   output logic [2:0]                   s_ar_size,
   output logic [1:0]                   s_ar_burst,
   output logic [1:0]                   s_ar_lock,
   output logic [3:0]                   s_ar_cache,
   output logic [2:0]                   s_ar_prot,
   input  logic [NUM_SLAVES-1:0]        s_r_valid,
   output logic [NUM_SLAVES-1:0]        s_r_ready,
   input  logic [NUM_SLAVES*ID_W-1:0]   s_r_id,
   input  logic [NUM_SLAVES*DATA_W-1:0] s_r_data,
   input  logic [NUM_SLAVES*2-1:0]      s_r_resp,
   input  logic [NUM_SLAVES-1:0]        s_r_last,
   output logic [NUM_SLAVES-1:0]        s_aw_valid,
   input  logic [NUM_SLAVES-1:0]        s_aw_ready,
   output logic [ID_W-1:0]              s_aw_id,
   output logic [ADDR_W-1:0]            s_aw_addr,
   output logic [7:0]                   s_aw_len,
   output logic [2:0]                   s_aw_size,
   output logic [1:0]                   s_aw_burst,
   output logic [1:0]                   s_aw_lock,
   output logic [3:0]                   s_aw_cache,
   output logic [2:0]                   s_aw_prot,
   output logic [NUM_SLAVES-1:0]        s_w_valid,
   input  logic [NUM_SLAVES-1:0]        s_w_ready,
   output logic [DATA_W-1:0]            s_w_data,
   output logic [DATA_W/8-1:0]          s_w_strb,
   output logic                         s_w_last,
   input  logic [NUM_SLAVES-1:0]        s_b_valid,
   output logic [NUM_SLAVES-1:0]        s_b_ready,
   input  logic [NUM_SLAVES*ID_W-1:0]   s_b_id,
   input  logic [NUM_SLAVES*2-1:0]      s_b_resp
);

`ifdef AXI_XBAR_DECERR_EN
   localparam int NT      = NUM_SLAVES + 1;
   localparam int DEF_IDX = NUM_SLAVES;
`else
   localparam int NT      = NUM_SLAVES;
   localparam int DEF_IDX = 0;
`endif
   localparam int SEL_W = $clog2(NT);
   localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

   typedef enum logic {W_IDLE, W_DATA} w_state_t;

   // Scan from the top index down so the lowest-index matching region wins.
   function automatic logic [SEL_W-1:0] decode(input logic [ADDR_W-1:0] addr);
      logic [SEL_W-1:0] sel;
      sel = SEL_W'(DEF_IDX);
      for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
         if (addr >= SLV_BASE[i*ADDR_W +: ADDR_W] &&
             (addr - SLV_BASE[i*ADDR_W +: ADDR_W]) < SLV_SIZE[i*ADDR_W +: ADDR_W])
            sel = SEL_W'(i);
      end
      return sel;
   endfunction

   logic [SEL_W-1:0] ar_dec, aw_dec, rd_sel, wr_sel, w_sel;
   logic [CNT_W-1:0] rd_cnt, b_cnt;
   logic             ar_ok, ar_go, ar_hs, r_done, rd_busy;
   logic             aw_ok, aw_go, aw_hs, w_done, b_hs, b_busy;
   w_state_t         w_state, w_next;

   logic [NT-1:0]     t_ar_ready, t_r_valid, t_r_last, t_aw_ready, t_w_ready, t_w_valid, t_b_valid;
   logic [ID_W-1:0]   t_r_id   [NT];
   logic [DATA_W-1:0] t_r_data [NT];
   logic [1:0]        t_r_resp [NT];
   logic [ID_W-1:0]   t_b_id   [NT];
   logic [1:0]        t_b_resp [NT];

   assign ar_dec  = decode(m_ar_addr);
   assign aw_dec  = decode(m_aw_addr);
   assign rd_busy = (rd_cnt != '0);
   assign b_busy  = (b_cnt != '0);

   assign ar_ok      = (!rd_busy || ar_dec == rd_sel) && rd_cnt < CNT_MAX;
   assign ar_go      = m_ar_valid && ar_ok;
   assign m_ar_ready = ar_ok && t_ar_ready[ar_dec];
   assign ar_hs      = m_ar_valid && m_ar_ready;

   assign m_r_valid = rd_busy && t_r_valid[rd_sel];
   assign m_r_id    = t_r_id[rd_sel];
   assign m_r_data  = t_r_data[rd_sel];
   assign m_r_resp  = t_r_resp[rd_sel];
   assign m_r_last  = t_r_last[rd_sel];
   assign r_done    = m_r_valid && m_r_ready && m_r_last;

   assign aw_ok      = (w_state == W_IDLE) && (!b_busy || aw_dec == wr_sel) && b_cnt < CNT_MAX;
   assign aw_go      = m_aw_valid && aw_ok;
   assign m_aw_ready = aw_ok && t_aw_ready[aw_dec];
   assign aw_hs      = m_aw_valid && m_aw_ready;
   assign w_done     = m_w_valid && m_w_ready && m_w_last;

   assign m_b_valid = b_busy && t_b_valid[wr_sel];
   assign m_b_id    = t_b_id[wr_sel];
   assign m_b_resp  = t_b_resp[wr_sel];
   assign b_hs      = m_b_valid && m_b_ready;

   assign {s_ar_id, s_ar_addr, s_ar_len, s_ar_size, s_ar_burst, s_ar_lock, s_ar_cache, s_ar_prot} =
          {m_ar_id, m_ar_addr, m_ar_len, m_ar_size, m_ar_burst, m_ar_lock, m_ar_cache, m_ar_prot};
   assign {s_aw_id, s_aw_addr, s_aw_len, s_aw_size, s_aw_burst, s_aw_lock, s_aw_cache, s_aw_prot} =
          {m_aw_id, m_aw_addr, m_aw_len, m_aw_size, m_aw_burst, m_aw_lock, m_aw_cache, m_aw_prot};
   assign {s_w_data, s_w_strb, s_w_last} = {m_w_data, m_w_strb, m_w_last};
   assign s_w_valid = t_w_valid[NUM_SLAVES-1:0];

   for (genvar i = 0; i < NUM_SLAVES; i++) begin : g_slv
      assign t_ar_ready[i] = s_ar_ready[i];
      assign t_aw_ready[i] = s_aw_ready[i];
      assign t_w_ready[i]  = s_w_ready[i];
      assign t_r_valid[i]  = s_r_valid[i];
      assign t_r_last[i]   = s_r_last[i];
      assign t_r_id[i]     = s_r_id[i*ID_W +: ID_W];
      assign t_r_data[i]   = s_r_data[i*DATA_W +: DATA_W];
      assign t_r_resp[i]   = s_r_resp[i*2 +: 2];
      assign t_b_valid[i]  = s_b_valid[i];
      assign t_b_id[i]     = s_b_id[i*ID_W +: ID_W];
      assign t_b_resp[i]   = s_b_resp[i*2 +: 2];
      assign s_ar_valid[i] = ar_go && (ar_dec == SEL_W'(i));
      assign s_aw_valid[i] = aw_go && (aw_dec == SEL_W'(i));
      assign s_r_ready[i]  = rd_busy && m_r_ready && (rd_sel == SEL_W'(i));
      assign s_b_ready[i]  = b_busy && m_b_ready && (wr_sel == SEL_W'(i));
   end

   // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_gate or negedge rst_n) begin
      if (!rst_n) begin
         rd_sel <= '0;
         rd_cnt <= '0;
         wr_sel <= '0;
         w_sel  <= '0;
         b_cnt  <= '0;
      end else begin
         if (ar_hs) rd_sel <= ar_dec;
         if (ar_hs && !r_done) rd_cnt <= rd_cnt + CNT_W'(1);
         else if (!ar_hs && r_done) rd_cnt <= rd_cnt - CNT_W'(1);
         if (aw_hs) begin
            wr_sel <= aw_dec;
            w_sel  <= aw_dec;
         end
         if (aw_hs && !b_hs) b_cnt <= b_cnt + CNT_W'(1);
         else if (!aw_hs && b_hs) b_cnt <= b_cnt - CNT_W'(1);
      end
   end

   always_ff @(posedge clk_gate or negedge rst_n) begin
      if (!rst_n) w_state <= W_IDLE;
      else        w_state <= w_next;
   end

   always_comb begin
      w_next = w_state;
      case (w_state)
         W_IDLE:  if (aw_hs)  w_next = W_DATA;
         W_DATA:  if (w_done) w_next = W_IDLE;
         default: w_next = W_IDLE;
      endcase
   end

   // NOTE: defaults first so no path through this block leaves an output unassigned (no latches).
   always_comb begin
      t_w_valid = '0;
      m_w_ready = 1'b0;
      if (w_state == W_DATA) begin
         t_w_valid[w_sel] = m_w_valid;
         m_w_ready        = t_w_ready[w_sel];
      end
   end

`ifdef AXI_XBAR_DECERR_EN
   localparam logic [SEL_W-1:0] ERR_SEL = SEL_W'(NUM_SLAVES);
   logic            err_rd_active, err_w_active, err_b_pend;
   logic [7:0]      err_rd_left;
   logic [ID_W-1:0] err_rd_id, err_b_id;

   assign t_ar_ready[NUM_SLAVES] = !rd_busy;
   assign t_r_valid[NUM_SLAVES]  = err_rd_active;
   assign t_r_last[NUM_SLAVES]   = (err_rd_left == 8'd0);
   assign t_r_id[NUM_SLAVES]     = err_rd_id;
   assign t_r_data[NUM_SLAVES]   = '0;
   assign t_r_resp[NUM_SLAVES]   = 2'b11;
   assign t_aw_ready[NUM_SLAVES] = !b_busy;
   assign t_w_ready[NUM_SLAVES]  = err_w_active;
   assign t_b_valid[NUM_SLAVES]  = err_b_pend;
   assign t_b_id[NUM_SLAVES]     = err_b_id;
   assign t_b_resp[NUM_SLAVES]   = 2'b11;

   always_ff @(posedge clk_gate or negedge rst_n) begin
      if (!rst_n) begin
         err_rd_active <= 1'b0;
         err_rd_left   <= '0;
         err_rd_id     <= '0;
         err_w_active  <= 1'b0;
         err_b_pend    <= 1'b0;
         err_b_id      <= '0;
      end else begin
         if (ar_hs && ar_dec == ERR_SEL) begin
            err_rd_active <= 1'b1;
            err_rd_left   <= m_ar_len;
            err_rd_id     <= m_ar_id;
         end else if (m_r_valid && m_r_ready && rd_sel == ERR_SEL) begin
            if (err_rd_left == 8'd0) err_rd_active <= 1'b0;
            else                     err_rd_left   <= err_rd_left - 8'd1;
         end
         if (aw_hs && aw_dec == ERR_SEL) begin
            err_w_active <= 1'b1;
            err_b_id     <= m_aw_id;
         end
         if (t_w_valid[NUM_SLAVES] && err_w_active && m_w_last) begin
            err_w_active <= 1'b0;
            err_b_pend   <= 1'b1;
         end
         if (b_hs && wr_sel == ERR_SEL) err_b_pend <= 1'b0;
      end
   end
`endif

   assert property (@(posedge clk_gate) disable iff (!rst_n) r_done |-> rd_busy);
   assert property (@(posedge clk_gate) disable iff (!rst_n) b_hs |-> b_busy);

endmodule

// File: tb/tb_axi_xbar_1xn.sv
// Directed bench for axi_xbar_1xn: decode table plus hand-written burst, stall, W-ordering and reset sequences.
// DECERR sequences run only when AXI_XBAR_DECERR_EN is defined for the build.
module tb_axi_xbar_1xn;
   localparam int NS = 4, AW = 32, DW = 32, IW = 4, MO = 2;

   logic clk_gate = 1'b0;
   logic rst_n;
   always #5 clk_gate = ~clk_gate;

   logic          m_ar_valid, m_ar_ready, m_r_valid, m_r_ready, m_r_last;
   logic [IW-1:0] m_ar_id, m_r_id, m_aw_id, m_b_id;
   logic [AW-1:0] m_ar_addr, m_aw_addr;
   logic [7:0]    m_ar_len, m_aw_len;
   logic [2:0]    m_ar_size, m_ar_prot, m_aw_size, m_aw_prot;
   logic [1:0]    m_ar_burst, m_ar_lock, m_aw_burst, m_aw_lock, m_r_resp, m_b_resp;
   logic [3:0]    m_ar_cache, m_aw_cache;
   logic [DW-1:0] m_r_data, m_w_data;
   logic          m_aw_valid, m_aw_ready, m_w_valid, m_w_ready, m_w_last, m_b_valid, m_b_ready;
   logic [DW/8-1:0] m_w_strb, s_w_strb;
   logic [NS-1:0] s_ar_valid, s_ar_ready, s_r_valid, s_r_ready, s_r_last;
   logic [NS-1:0] s_aw_valid, s_aw_ready, s_w_valid, s_w_ready, s_b_valid, s_b_ready;
   logic [IW-1:0] s_ar_id, s_aw_id;
   logic [AW-1:0] s_ar_addr, s_aw_addr;
   logic [7:0]    s_ar_len, s_aw_len;
   logic [2:0]    s_ar_size, s_ar_prot, s_aw_size, s_aw_prot;
   logic [1:0]    s_ar_burst, s_ar_lock, s_aw_burst, s_aw_lock;
   logic [3:0]    s_ar_cache, s_aw_cache;
   logic [NS*IW-1:0] s_r_id, s_b_id;
   logic [NS*DW-1:0] s_r_data;
   logic [NS*2-1:0]  s_r_resp, s_b_resp;
   logic [DW-1:0] s_w_data;
   logic          s_w_last;

   axi_xbar_1xn #(
      .NUM_SLAVES(NS), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW), .MAX_OUTSTANDING(MO),
      .SLV_BASE({32'h0000_1800, 32'h0001_0000, 32'h0000_1000, 32'h0000_0000}),
      .SLV_SIZE({32'h0000_1000, 32'h0000_0100, 32'h0000_1000, 32'h0000_1000})
   ) dut (
      .clk_gate(clk_gate), .rst_n(rst_n),
      .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready), .m_ar_id(m_ar_id), .m_ar_addr(m_ar_addr),
      .m_ar_len(m_ar_len), .m_ar_size(m_ar_size), .m_ar_burst(m_ar_burst), .m_ar_lock(m_ar_lock),
      .m_ar_cache(m_ar_cache), .m_ar_prot(m_ar_prot),
      .m_r_valid(m_r_valid), .m_r_ready(m_r_ready), .m_r_id(m_r_id), .m_r_data(m_r_data),
      .m_r_resp(m_r_resp), .m_r_last(m_r_last),
      .m_aw_valid(m_aw_valid), .m_aw_ready(m_aw_ready), .m_aw_id(m_aw_id), .m_aw_addr(m_aw_addr),
      .m_aw_len(m_aw_len), .m_aw_size(m_aw_size), .m_aw_burst(m_aw_burst), .m_aw_lock(m_aw_lock),
      .m_aw_cache(m_aw_cache), .m_aw_prot(m_aw_prot),
      .m_w_valid(m_w_valid), .m_w_ready(m_w_ready), .m_w_data(m_w_data), .m_w_strb(m_w_strb),
      .m_w_last(m_w_last),
      .m_b_valid(m_b_valid), .m_b_ready(m_b_ready), .m_b_id(m_b_id), .m_b_resp(m_b_resp),
      .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready), .s_ar_id(s_ar_id), .s_ar_addr(s_ar_addr),
      .s_ar_len(s_ar_len), .s_ar_size(s_ar_size), .s_ar_burst(s_ar_burst), .s_ar_lock(s_ar_lock),
      .s_ar_cache(s_ar_cache), .s_ar_prot(s_ar_prot),
      .s_r_valid(s_r_valid), .s_r_ready(s_r_ready), .s_r_id(s_r_id), .s_r_data(s_r_data),
      .s_r_resp(s_r_resp), .s_r_last(s_r_last),
      .s_aw_valid(s_aw_valid), .s_aw_ready(s_aw_ready), .s_aw_id(s_aw_id), .s_aw_addr(s_aw_addr),
      .s_aw_len(s_aw_len), .s_aw_size(s_aw_size), .s_aw_burst(s_aw_burst), .s_aw_lock(s_aw_lock),
      .s_aw_cache(s_aw_cache), .s_aw_prot(s_aw_prot),
      .s_w_valid(s_w_valid), .s_w_ready(s_w_ready), .s_w_data(s_w_data), .s_w_strb(s_w_strb),
      .s_w_last(s_w_last),
      .s_b_valid(s_b_valid), .s_b_ready(s_b_ready), .s_b_id(s_b_id), .s_b_resp(s_b_resp)
   );

   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Inputs change 1 ns after the rising edge; checks follow 1 ns later.
   task automatic tick();
      @(posedge clk_gate);
      #1;
   endtask

   typedef struct {
      string       name;
      logic [31:0] addr;
      logic [3:0]  exp_sel;
      logic        exp_ready;
   } dec_vec_t;

   dec_vec_t vecs [10];

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      vecs[0] = '{"s0_low",      32'h0000_0000, 4'b0001, 1'b1};
      vecs[1] = '{"s0_high",     32'h0000_0FFF, 4'b0001, 1'b1};
      vecs[2] = '{"s1_low",      32'h0000_1000, 4'b0010, 1'b0};
      vecs[3] = '{"s1_overlap",  32'h0000_1FFC, 4'b0010, 1'b0};
      vecs[4] = '{"s3_low",      32'h0000_2000, 4'b1000, 1'b0};
      vecs[5] = '{"s3_high",     32'h0000_27FF, 4'b1000, 1'b0};
      vecs[7] = '{"s2_low",      32'h0001_0000, 4'b0100, 1'b1};
      vecs[8] = '{"s2_high",     32'h0001_00FF, 4'b0100, 1'b1};
`ifdef AXI_XBAR_DECERR_EN
      vecs[6] = '{"unmap_2800",  32'h0000_2800, 4'b0000, 1'b1};
      vecs[9] = '{"unmap_10100", 32'h0001_0100, 4'b0000, 1'b1};
`else
      vecs[6] = '{"unmap_2800",  32'h0000_2800, 4'b0001, 1'b1};
      vecs[9] = '{"unmap_10100", 32'h0001_0100, 4'b0001, 1'b1};
`endif

      rst_n = 1'b0;
      {m_ar_valid, m_r_ready, m_aw_valid, m_w_valid, m_w_last, m_b_ready} = '0;
      {m_ar_id, m_ar_addr, m_ar_len, m_aw_id, m_aw_addr, m_aw_len, m_w_data} = '0;
      {m_ar_size, m_ar_burst, m_ar_lock, m_ar_cache, m_ar_prot} = {3'd2, 2'b01, 2'b00, 4'h3, 3'd0};
      {m_aw_size, m_aw_burst, m_aw_lock, m_aw_cache, m_aw_prot} = {3'd2, 2'b01, 2'b00, 4'h3, 3'd0};
      m_w_strb = '1;
      s_ar_ready = '1; s_aw_ready = '1; s_w_ready = '1;
      {s_r_valid, s_r_last, s_b_valid} = '0;
      {s_r_id, s_r_data, s_r_resp, s_b_id, s_b_resp} = '0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      // Reset state: stray slave responses and early W must not leak through.
      s_r_valid = 4'b0001; s_r_last = 4'b0001; s_b_valid = 4'b0001;
      m_w_valid = 1'b1; m_r_ready = 1'b1; m_b_ready = 1'b1;
      #1;
      check("rst_m_r_valid", m_r_valid, 1'b0);
      check("rst_m_b_valid", m_b_valid, 1'b0);
      check("rst_m_w_ready", m_w_ready, 1'b0);
      check("rst_s_w_valid", s_w_valid, 4'b0000);
      s_r_valid = '0; s_r_last = '0; s_b_valid = '0;
      m_w_valid = 1'b0; m_r_ready = 1'b0; m_b_ready = 1'b0;
      tick();

      // Decode table: combinational only, valid dropped before each edge.
      s_ar_ready = 4'b0101;
      for (int i = 0; i < 10; i++) begin
         m_ar_addr = vecs[i].addr; m_aw_addr = vecs[i].addr;
         m_ar_valid = 1'b1; m_aw_valid = 1'b1;
         #1;
         check({"dec_ar_", vecs[i].name}, s_ar_valid, vecs[i].exp_sel);
         check({"dec_rdy_", vecs[i].name}, m_ar_ready, vecs[i].exp_ready);
         check({"dec_aw_", vecs[i].name}, s_aw_valid, vecs[i].exp_sel);
         m_ar_valid = 1'b0; m_aw_valid = 1'b0;
         tick();
      end
      s_ar_ready = '1;

      // Test 1: 4-beat burst from slave 2, slave 0 also presenting R as a distractor.
      m_ar_valid = 1'b1; m_ar_addr = 32'h0001_0040; m_ar_len = 8'd3; m_ar_id = 4'd2;
      #1;
      check("t1_s_ar_valid", s_ar_valid, 4'b0100);
      check("t1_m_ar_ready", m_ar_ready, 1'b1);
      tick();
      m_ar_valid = 1'b0;
      m_r_ready = 1'b1;
      s_r_valid = 4'b0101;
      s_r_data[0 +: 32] = 32'hDEAD_0000;
      s_r_id[8 +: 4] = 4'd2;
      for (int b = 0; b < 4; b++) begin
         s_r_data[64 +: 32] = 32'hC200_0000 + 32'(b);
         s_r_last[2] = (b == 3);
         #1;
         check("t1_r_valid", m_r_valid, 1'b1);
         check("t1_r_data", m_r_data, 32'hC200_0000 + 32'(b));
         check("t1_r_id", m_r_id, 4'd2);
         check("t1_r_last", m_r_last, (b == 3));
         check("t1_s_r_ready", s_r_ready, 4'b0100);
         tick();
      end
      #1;
      check("t1_r_valid_after", m_r_valid, 1'b0);
      check("t1_rd_cnt_after", dut.rd_cnt, 0);
      s_r_valid = '0; s_r_last = '0; m_r_ready = 1'b0;
      tick();

      // Test 2: two ARs to slave 1, then AR to slave 0 stalls until both lasts.
      m_ar_valid = 1'b1; m_ar_addr = 32'h0000_1000; m_ar_len = 8'd0;
      #1;
      check("t2_ar1_ready", m_ar_ready, 1'b1);
      tick();
      check("t2_ar2_ready", m_ar_ready, 1'b1);
      tick();
      m_ar_addr = 32'h0000_0100;
      #1;
      check("t2_ar3_stall_full", m_ar_ready, 1'b0);
      check("t2_ar3_no_valid", s_ar_valid, 4'b0000);
      s_r_valid = 4'b0010; s_r_last = 4'b0010; m_r_ready = 1'b1;
      tick();
      check("t2_ar3_stall_target", m_ar_ready, 1'b0);
      check("t2_s_r_ready_s1", s_r_ready, 4'b0010);
      tick();
      s_r_valid = '0; s_r_last = '0;
      #1;
      check("t2_ar3_fwd_ready", m_ar_ready, 1'b1);
      check("t2_ar3_fwd_valid", s_ar_valid, 4'b0001);
      tick();
      m_ar_valid = 1'b0;
      s_r_valid = 4'b0001; s_r_last = 4'b0001;
      tick();
      s_r_valid = '0; s_r_last = '0; m_r_ready = 1'b0;
      check("t2_rd_cnt_drained", dut.rd_cnt, 0);
      tick();

      // Test 3: MAX_OUTSTANDING=2 stall, then R last coincident with a new AR.
      m_ar_valid = 1'b1; m_ar_addr = 32'h0000_0010; m_ar_len = 8'd0;
      s_r_valid = 4'b0001; s_r_last = 4'b0001;
      tick();
      tick();
      check("t3_cnt_full", dut.rd_cnt, 2);
      check("t3_ar_stall", m_ar_ready, 1'b0);
      m_r_ready = 1'b1;
      tick();
      check("t3_cnt_after_last", dut.rd_cnt, 1);
      check("t3_ar_open", m_ar_ready, 1'b1);
      tick();
      check("t3_cnt_simul", dut.rd_cnt, 1);
      m_r_ready = 1'b0;
      tick();
      check("t3_cnt_refill", dut.rd_cnt, 2);
      check("t3_ar_stall2", m_ar_ready, 1'b0);
      m_ar_valid = 1'b0; m_r_ready = 1'b1;
      tick();
      tick();
      check("t3_cnt_drained", dut.rd_cnt, 0);
      s_r_valid = '0; s_r_last = '0; m_r_ready = 1'b0;
      tick();

      // Test 4: W ahead of AW stalls; 2 beats to slave 3; B from slave 3 only.
      m_w_valid = 1'b1; m_w_data = 32'h1111_1111; m_w_last = 1'b0;
      for (int c = 0; c < 3; c++) begin
         #1;
         check("t4_w_stall_ready", m_w_ready, 1'b0);
         check("t4_w_stall_valid", s_w_valid, 4'b0000);
         tick();
      end
      m_aw_valid = 1'b1; m_aw_addr = 32'h0000_2000; m_aw_len = 8'd1; m_aw_id = 4'd7;
      #1;
      check("t4_s_aw_valid", s_aw_valid, 4'b1000);
      check("t4_m_aw_ready", m_aw_ready, 1'b1);
      tick();
      m_aw_valid = 1'b0;
      check("t4_w1_ready", m_w_ready, 1'b1);
      check("t4_w1_valid", s_w_valid, 4'b1000);
      check("t4_w1_data", s_w_data, 32'h1111_1111);
      tick();
      m_w_data = 32'h2222_2222; m_w_last = 1'b1;
      #1;
      check("t4_w2_valid", s_w_valid, 4'b1000);
      check("t4_w2_last", s_w_last, 1'b1);
      tick();
      m_w_valid = 1'b0; m_w_last = 1'b0;
      check("t4_w_idle_ready", m_w_ready, 1'b0);
      s_b_valid = 4'b1001; s_b_id = {4'h7, 4'h0, 4'h0, 4'h3}; s_b_resp = {2'b00, 2'b00, 2'b00, 2'b01};
      m_b_ready = 1'b1;
      #1;
      check("t4_b_valid", m_b_valid, 1'b1);
      check("t4_b_id", m_b_id, 4'h7);
      check("t4_b_resp", m_b_resp, 2'b00);
      check("t4_s_b_ready", s_b_ready, 4'b1000);
      tick();
      check("t4_b_done", m_b_valid, 1'b0);
      s_b_valid = '0; m_b_ready = 1'b0;
      tick();

`ifdef AXI_XBAR_DECERR_EN
      // Test 5: DECERR read and write terminations.
      m_ar_valid = 1'b1; m_ar_addr = 32'h0000_3000; m_ar_len = 8'd2; m_ar_id = 4'd5;
      #1;
      check("t5_ar_no_slave", s_ar_valid, 4'b0000);
      check("t5_ar_ready", m_ar_ready, 1'b1);
      tick();
      m_ar_valid = 1'b0; m_r_ready = 1'b1;
      for (int b = 0; b < 3; b++) begin
         check("t5_r_valid", m_r_valid, 1'b1);
         check("t5_r_id", m_r_id, 4'd5);
         check("t5_r_resp", m_r_resp, 2'b11);
         check("t5_r_data", m_r_data, 32'h0);
         check("t5_r_last", m_r_last, (b == 2));
         tick();
      end
      check("t5_r_done", m_r_valid, 1'b0);
      m_r_ready = 1'b0;
      m_aw_valid = 1'b1; m_aw_addr = 32'h0000_3000; m_aw_len = 8'd0; m_aw_id = 4'd9;
      #1;
      check("t5_aw_ready", m_aw_ready, 1'b1);
      tick();
      m_aw_valid = 1'b0; m_w_valid = 1'b1; m_w_last = 1'b1;
      check("t5_w_ready", m_w_ready, 1'b1);
      tick();
      m_w_valid = 1'b0; m_w_last = 1'b0; m_b_ready = 1'b1;
      check("t5_b_valid", m_b_valid, 1'b1);
      check("t5_b_id", m_b_id, 4'd9);
      check("t5_b_resp", m_b_resp, 2'b11);
      tick();
      check("t5_b_done", m_b_valid, 1'b0);
      m_b_ready = 1'b0;
      tick();
`else
      // Test 6a: unmapped address falls back to slave 0.
      m_ar_valid = 1'b1; m_ar_addr = 32'h0000_3000; m_ar_len = 8'd0;
      #1;
      check("t6_unmap_s0", s_ar_valid, 4'b0001);
      check("t6_unmap_ready", m_ar_ready, 1'b1);
      tick();
      m_ar_valid = 1'b0;
      s_r_valid = 4'b0001; s_r_last = 4'b0001; m_r_ready = 1'b1;
      tick();
      s_r_valid = '0; s_r_last = '0; m_r_ready = 1'b0;
      check("t6_unmap_drained", dut.rd_cnt, 0);
`endif

      // Test 6b: reset mid-burst abandons all tracking.
      m_ar_valid = 1'b1; m_ar_addr = 32'h0000_0000; m_ar_len = 8'd3;
      m_aw_valid = 1'b1; m_aw_addr = 32'h0000_1000; m_aw_len = 8'd3;
      tick();
      m_ar_valid = 1'b0; m_aw_valid = 1'b0; m_w_valid = 1'b1;
      check("t6_pre_w_ready", m_w_ready, 1'b1);
      check("t6_pre_rd_cnt", dut.rd_cnt, 1);
      rst_n = 1'b0;
      s_r_valid = 4'b0001;
      #1;
      check("t6_rst_rd_cnt", dut.rd_cnt, 0);
      check("t6_rst_b_cnt", dut.b_cnt, 0);
      check("t6_rst_w_ready", m_w_ready, 1'b0);
      check("t6_rst_s_w_valid", s_w_valid, 4'b0000);
      check("t6_rst_r_valid", m_r_valid, 1'b0);
      tick();
      rst_n = 1'b1;
      tick();
      check("t6_post_w_ready", m_w_ready, 1'b0);
      check("t6_post_r_valid", m_r_valid, 1'b0);
      s_r_valid = '0; m_w_valid = 1'b0;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
